parity_engine: RTL and testbench
================================

# parity_engine

Streaming parity generator/checker for the UART Tx and Rx paths. It replaces the combinational 8-bit, 2-mode parity unit with a sequential engine. Data bits arrive serially, LSB first, one per qualified cycle. The engine takes a parametrised word width and five parity modes. In check mode it compares the received parity bit and keeps a saturating error count. The Tx frame FSM and the Rx sampler both instantiate it and feed bits in the cycle they shift or sample them.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal 1..16.
- ERR_CNT_WIDTH, 8, width of the saturating parity-error counter; legal 1..16.

- Clock  in  1  single system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begins a frame; accepted only in IDLE.
- Mode  in  3  000 none, 001 odd, 010 even, 011 mark, 100 space; 101–111 are treated as none. Latched at Start.
- CheckEn  in  1  0 = generate, 1 = check received parity. Latched at Start.
- BitValid  in  1  qualifies BitIn.
- BitIn  in  1  serial data bit; in check mode, also the received parity bit.
- Abort  in  1  drops the current frame.
- ClrErr  in  1  clears ErrCount.
- Busy  out  1  high in ACCUM and RXPAR.
- ParityValid  out  1  one-cycle pulse; ParityBit and ParityErr are valid in this cycle.
- ParityBit  out  1  expected or generated parity bit, registered, held until the next ParityValid.
- ParityErr  out  1  one-cycle pulse, coincident with ParityValid; only ever set in check mode.
- ErrCount  out  ERR_CNT_WIDTH  count of parity errors, saturating at all-ones.

## Operation
- State registers: ModeReg, ChkReg, Acc (1 bit), BitCnt (width $clog2(DATA_WIDTH+1)), and the state.
- **IDLE:**
  - On Start: ModeReg <= Mode, ChkReg <= CheckEn, Acc <= 0, BitCnt <= 0, go to ACCUM.
  - BitValid is ignored in IDLE, including in the Start cycle.
- **ACCUM:**
  - Each BitValid: Acc <= Acc ^ BitIn and BitCnt <= BitCnt + 1.
  - On the DATA_WIDTH-th valid bit, compute the expected parity P from Acc including that bit:
    - odd: ~Acc
    - even: Acc
    - mark: 1
    - space: 0
    - none: 0
  - ParityBit <= P.
  - If ChkReg = 0 or the mode is none: pulse ParityValid and go to IDLE.
  - Otherwise go to RXPAR.
- **RXPAR:**
  - The next BitValid carries the received parity bit.
  - ParityErr <= (BitIn != ParityBit), pulse ParityValid, go to IDLE.
  - On an error, ErrCount increments unless it is already all-ones.
- **Abort** in ACCUM or RXPAR: go to IDLE with no ParityValid and no ParityErr; ParityBit and ErrCount are unchanged. Abort in IDLE has no effect.
- Start while Busy is ignored: the latched mode is unchanged and the count is not restarted.
- **Abort and Start in the same cycle:** Abort wins, and the Start is dropped.
- **Abort and the final BitValid in the same cycle:** Abort wins, with no ParityValid.
- **ClrErr and an error increment in the same cycle:** ErrCount <= 0; clear wins.
- Mode and CheckEn changes after Start have no effect until the next Start.

## Timing
- **Reset:** state = IDLE; Busy, ParityValid, ParityBit, ParityErr, Acc, BitCnt and ErrCount = 0. Reset overrides every other input, including mid-frame.
- Busy rises the cycle after Start is accepted.
- **Generate, or mode none:** ParityValid is asserted in the cycle after the DATA_WIDTH-th BitValid edge, and Busy is 0 in that same cycle.
- **Check:** ParityValid and ParityErr are asserted in the cycle after the received-parity BitValid, and Busy is 0 in that cycle.
- ErrCount updates on the same edge that raises ParityErr.
- Bits may arrive with arbitrary idle gaps; back-to-back BitValid is legal.
- **Minimum frame-to-frame spacing:** Start is accepted in the ParityValid cycle, because the state is already IDLE.

## Test plan
- **Generate, DATA_WIDTH=8, LSB first, with a 1-cycle gap after Start:**
  - even, 8'b00001111 -> ParityBit=0, with ParityValid one cycle after the 8th bit.
  - odd, 8'b00001111 -> ParityBit=1.
  - even, 8'b10101111 -> ParityBit=0.
- **Check, odd, 8'b10111101 (6 ones):**
  - received parity 0 -> ParityErr=1, ErrCount 0->1.
  - received parity 1 -> ParityErr=0, ErrCount unchanged.
- **Other modes, data 8'b10101001:**
  - mark -> ParityBit=1.
  - space -> ParityBit=0.
  - Mode=3'b111 with CheckEn=1 -> ParityValid the cycle after the 8th bit, no RXPAR phase, ParityErr=0.
- **Control:**
  - Abort after 4 bits -> Busy=0 next cycle and no ParityValid.
  - Start during ACCUM -> ignored; the frame still completes with the original Mode.
  - Reset asserted mid-frame -> all outputs 0 next cycle.
- **Counter, ERR_CNT_WIDTH=2:**
  - 4 consecutive erroneous frames -> ErrCount stays at 3.
  - ClrErr coinciding with an error -> ErrCount=0 and ParityErr=1.
- **Width, DATA_WIDTH=5:**
  - even, 5'b10110 -> ParityBit=1, with ParityValid one cycle after the 5th bit.
  - back-to-back frames with Start in the ParityValid cycle -> both frames are correct.

Source files
------------

// File: rtl/parity_engine.sv
// Streaming parity generator/checker: data bits arrive serially LSB first, parity is
// produced (generate) or compared against a trailing received bit (check).
module parity_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [2:0]               mode_i,
    input  logic                     check_en_i,
    input  logic                     bit_valid_i,
    input  logic                     bit_in_i,
    input  logic                     abort_i,
    input  logic                     clr_err_i,
    output logic                     busy_o,
    output logic                     parity_valid_o,
    output logic                     parity_bit_o,
    output logic                     parity_err_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        RXPAR = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        MODE_NONE  = 3'd0,
        MODE_ODD   = 3'd1,
        MODE_EVEN  = 3'd2,
        MODE_MARK  = 3'd3,
        MODE_SPACE = 3'd4
    } mode_e;

    state_e                   state_q, state_d;
    logic [2:0]               mode_q, mode_d;
    logic                     chk_q, chk_d;
    logic                     acc_q, acc_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic                     parity_bit_q, parity_bit_d;
    logic                     parity_valid_q, parity_valid_d;
    logic                     parity_err_q, parity_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     err_inc;
    logic                     acc_next;

    // Codes 101-111 behave exactly like "none".
    function automatic logic expected_parity(input logic [2:0] mode, input logic acc);
        case (mode)
            MODE_ODD:  return ~acc;
            MODE_EVEN: return acc;
            MODE_MARK: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic mode_is_none(input logic [2:0] mode);
        return (mode == MODE_NONE) || (mode > MODE_SPACE);
    endfunction

    assign acc_next = acc_q ^ bit_in_i;

    always_comb begin
        // NOTE: every next-state value gets a default before the case so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        mode_d         = mode_q;
        chk_d          = chk_q;
        acc_d          = acc_q;
        bit_cnt_d      = bit_cnt_q;
        parity_bit_d   = parity_bit_q;
        parity_valid_d = 1'b0;
        parity_err_d   = 1'b0;
        err_inc        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    mode_d    = mode_i;
                    chk_d     = check_en_i;
                    acc_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (bit_valid_i) begin
                    acc_d     = acc_next;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_IDX) begin
                        parity_bit_d = expected_parity(mode_q, acc_next);
                        if (!chk_q || mode_is_none(mode_q)) begin
                            parity_valid_d = 1'b1;
                            state_d        = IDLE;
                        end else begin
                            state_d = RXPAR;
                        end
                    end
                end
            end
            RXPAR: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (bit_valid_i) begin
                    parity_valid_d = 1'b1;
                    parity_err_d   = (bit_in_i != parity_bit_q);
                    err_inc        = (bit_in_i != parity_bit_q);
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear has priority over a coincident increment.
        if (clr_err_i) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            mode_q         <= 3'd0;
            chk_q          <= 1'b0;
            acc_q          <= 1'b0;
            bit_cnt_q      <= '0;
            parity_bit_q   <= 1'b0;
            parity_valid_q <= 1'b0;
            parity_err_q   <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            chk_q          <= chk_d;
            acc_q          <= acc_d;
            bit_cnt_q      <= bit_cnt_d;
            parity_bit_q   <= parity_bit_d;
            parity_valid_q <= parity_valid_d;
            parity_err_q   <= parity_err_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign parity_valid_o = parity_valid_q;
    assign parity_bit_o   = parity_bit_q;
    assign parity_err_o   = parity_err_q;
    assign err_count_o    = err_cnt_q;

endmodule

// File: tb/tb_parity_engine.sv
// Bench for parity_engine: two instances (8-bit data with 2-bit counter, 5-bit data with
// 8-bit counter) checked every cycle against a frame-level model, plus literal checks.
module tb_parity_engine;

    localparam logic [2:0] M_NONE  = 3'd0;
    localparam logic [2:0] M_ODD   = 3'd1;
    localparam logic [2:0] M_EVEN  = 3'd2;
    localparam logic [2:0] M_MARK  = 3'd3;
    localparam logic [2:0] M_SPACE = 3'd4;

    logic       clk;
    logic       rst;
    logic       start_s [2];
    logic [2:0] mode_s  [2];
    logic       chk_s   [2];
    logic       bv_s    [2];
    logic       bin_s   [2];
    logic       abort_s [2];
    logic       clr_s   [2];
    logic       busy_s  [2];
    logic       pv_s    [2];
    logic       pb_s    [2];
    logic       pe_s    [2];
    logic [1:0] ec_a;
    logic [7:0] ec_b;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    parity_engine #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) u_w8 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[0]), .mode_i(mode_s[0]),
        .check_en_i(chk_s[0]), .bit_valid_i(bv_s[0]), .bit_in_i(bin_s[0]),
        .abort_i(abort_s[0]), .clr_err_i(clr_s[0]), .busy_o(busy_s[0]),
        .parity_valid_o(pv_s[0]), .parity_bit_o(pb_s[0]), .parity_err_o(pe_s[0]),
        .err_count_o(ec_a)
    );

    parity_engine #(.DATA_WIDTH(5), .ERR_CNT_WIDTH(8)) u_w5 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[1]), .mode_i(mode_s[1]),
        .check_en_i(chk_s[1]), .bit_valid_i(bv_s[1]), .bit_in_i(bin_s[1]),
        .abort_i(abort_s[1]), .clr_err_i(clr_s[1]), .busy_o(busy_s[1]),
        .parity_valid_o(pv_s[1]), .parity_bit_o(pb_s[1]), .parity_err_o(pe_s[1]),
        .err_count_o(ec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level reference: counts ones and bits, derives parity from the count.
    typedef struct {
        int         phase;   // 0 idle, 1 collecting data, 2 awaiting parity bit
        logic [2:0] mode;
        logic       chk;
        int         ones;
        int         nbits;
        logic       pv;
        logic       pbit;
        logic       perr;
        int         ec;
    } model_t;

    model_t m [2];

    function automatic int width_of(int k);
        return (k == 0) ? 8 : 5;
    endfunction

    function automatic int ec_max(int k);
        return (k == 0) ? 3 : 255;
    endfunction

    function automatic logic ref_parity(logic [2:0] mode, int ones);
        case (mode)
            M_ODD:   return (ones % 2) == 0;
            M_EVEN:  return (ones % 2) == 1;
            M_MARK:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic model_t step(model_t cur, int k, logic r, logic st, logic [2:0] md,
                                    logic ce, logic bv, logic bi, logic ab, logic cl);
        model_t nx = cur;
        if (r) begin
            nx.phase = 0; nx.ones = 0; nx.nbits = 0;
            nx.pv = 0; nx.pbit = 0; nx.perr = 0; nx.ec = 0;
            return nx;
        end
        nx.pv   = 0;
        nx.perr = 0;
        case (cur.phase)
            0: if (st && !ab) begin
                nx.phase = 1; nx.mode = md; nx.chk = ce; nx.ones = 0; nx.nbits = 0;
            end
            1: if (ab) nx.phase = 0;
               else if (bv) begin
                nx.ones  = cur.ones + int'(bi);
                nx.nbits = cur.nbits + 1;
                if (nx.nbits == width_of(k)) begin
                    nx.pbit = ref_parity(cur.mode, nx.ones);
                    if (!cur.chk || cur.mode == M_NONE || cur.mode > M_SPACE) begin
                        nx.pv = 1; nx.phase = 0;
                    end else begin
                        nx.phase = 2;
                    end
                end
            end
            default: if (ab) nx.phase = 0;
               else if (bv) begin
                nx.pv = 1;
                nx.perr = (bi != cur.pbit);
                nx.phase = 0;
                if (nx.perr && cur.ec < ec_max(k)) nx.ec = cur.ec + 1;
            end
        endcase
        if (cl) nx.ec = 0;
        return nx;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            m[k] <= step(m[k], k, rst, start_s[k], mode_s[k], chk_s[k], bv_s[k],
                         bin_s[k], abort_s[k], clr_s[k]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(logic busy, logic pv, logic pb, logic pe, int ec);
        logic [31:0] e = ec;
        return {12'd0, busy, pv, pb, pe, e[15:0]};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_w8", pack(busy_s[0], pv_s[0], pb_s[0], pe_s[0], int'(ec_a)),
                  pack(m[0].phase != 0, m[0].pv, m[0].pbit, m[0].perr, m[0].ec));
            check("cmp_w5", pack(busy_s[1], pv_s[1], pb_s[1], pe_s[1], int'(ec_b)),
                  pack(m[1].phase != 0, m[1].pv, m[1].pbit, m[1].perr, m[1].ec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(int k, logic [2:0] md, logic ce, int gap);
        start_s[k] = 1'b1; mode_s[k] = md; chk_s[k] = ce;
        tick();
        start_s[k] = 1'b0;
        mode_s[k]  = 3'($urandom);   // must not affect the running frame
        chk_s[k]   = 1'($urandom);
        repeat (gap) tick();
    endtask

    task automatic send_bits(int k, logic [15:0] data, int n);
        for (int i = 0; i < n; i++) begin
            bv_s[k] = 1'b1; bin_s[k] = data[i];
            tick();
        end
        bv_s[k] = 1'b0;
    endtask

    task automatic send_par(int k, logic b);
        bv_s[k] = 1'b1; bin_s[k] = b;
        tick();
        bv_s[k] = 1'b0;
    endtask

    task automatic gen_frame(int k, logic [2:0] md, logic ce, logic [15:0] data, int n, int gap);
        start_frame(k, md, ce, gap);
        send_bits(k, data, n);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 0; mode_s[k] = 0; chk_s[k] = 0; bv_s[k] = 0;
            bin_s[k] = 0; abort_s[k] = 0; clr_s[k] = 0;
        end
        tick();
        cmp_en = 1;
        tick();
        rst = 1'b0;
        check("rst_busy", busy_s[0], 0);
        check("rst_ec", ec_a, 0);

        gen_frame(0, M_EVEN, 0, 16'h0F, 8, 1);
        check("even_0f_pv", pv_s[0], 1);
        check("even_0f_bit", pb_s[0], 0);
        check("even_0f_busy", busy_s[0], 0);
        gen_frame(0, M_ODD, 0, 16'h0F, 8, 1);
        check("odd_0f_bit", pb_s[0], 1);
        gen_frame(0, M_EVEN, 0, 16'hAF, 8, 1);
        check("even_af_bit", pb_s[0], 0);

        gen_frame(0, M_ODD, 1, 16'hBD, 8, 1);
        check("chk_rxpar_busy", busy_s[0], 1);
        check("chk_rxpar_nopv", pv_s[0], 0);
        send_par(0, 1'b0);
        check("chk_bad_pv", pv_s[0], 1);
        check("chk_bad_err", pe_s[0], 1);
        check("chk_bad_ec", ec_a, 1);
        gen_frame(0, M_ODD, 1, 16'hBD, 8, 1);
        send_par(0, 1'b1);
        check("chk_good_err", pe_s[0], 0);
        check("chk_good_ec", ec_a, 1);

        gen_frame(0, M_MARK, 0, 16'hA9, 8, 1);
        check("mark_bit", pb_s[0], 1);
        gen_frame(0, M_SPACE, 0, 16'hA9, 8, 1);
        check("space_bit", pb_s[0], 0);
        gen_frame(0, 3'b111, 1, 16'hA9, 8, 1);
        check("none_chk_pv", pv_s[0], 1);
        check("none_chk_err", pe_s[0], 0);
        check("none_chk_busy", busy_s[0], 0);

        start_frame(0, M_EVEN, 0, 1);
        send_bits(0, 16'h0F, 4);
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        check("abort_busy", busy_s[0], 0);
        check("abort_pv", pv_s[0], 0);
        send_bits(0, 16'h0F, 4);
        check("abort_ignored_bits", pv_s[0], 0);

        start_frame(0, M_EVEN, 0, 0);
        send_bits(0, 16'h0F, 4);
        start_s[0] = 1'b1; mode_s[0] = M_ODD;
        tick();
        start_s[0] = 1'b0;
        send_bits(0, 16'h00, 4);
        check("busy_start_pv", pv_s[0], 1);
        check("busy_start_bit", pb_s[0], 0);

        start_frame(0, M_ODD, 1, 0);
        send_bits(0, 16'hBD, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy_s[0], 0);
        check("midrst_ec", ec_a, 0);

        for (int i = 0; i < 4; i++) begin
            gen_frame(0, M_ODD, 1, 16'hBD, 8, 0);
            send_par(0, 1'b0);
            check("sat_ec", ec_a, (i < 3) ? i + 1 : 3);
        end
        gen_frame(0, M_ODD, 1, 16'hBD, 8, 0);
        clr_s[0] = 1'b1;
        send_par(0, 1'b0);
        clr_s[0] = 1'b0;
        check("clr_err_pulse", pe_s[0], 1);
        check("clr_ec", ec_a, 0);

        gen_frame(1, M_EVEN, 0, 16'b10110, 5, 1);
        check("w5_pv", pv_s[1], 1);
        check("w5_bit", pb_s[1], 1);
        gen_frame(1, M_ODD, 0, 16'b00111, 5, 0);
        check("w5_b2b_pv", pv_s[1], 1);
        check("w5_b2b_bit", pb_s[1], 0);

        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                start_s[k] = ($urandom_range(0, 5) == 0);
                mode_s[k]  = 3'($urandom);
                chk_s[k]   = 1'($urandom);
                bv_s[k]    = ($urandom_range(0, 2) != 0);
                bin_s[k]   = 1'($urandom);
                abort_s[k] = ($urandom_range(0, 39) == 0);
                clr_s[k]   = ($urandom_range(0, 29) == 0);
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 0; bv_s[k] = 0; abort_s[k] = 0; clr_s[k] = 0;
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
